// File: rtl/cell_hist_accum.sv
// HOG cell histogram accumulator.
// Sums gradient magnitudes per orientation bin over one cell of pixels, then streams
// the saturated 8-bit bin values out one per handshake before starting the next cell.
module cell_hist_accum #(
    parameter int unsigned PIX_PER_CELL = 64,
    parameter int unsigned NBINS        = 9
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iValid,
    input  logic [7:0] iMag,
    input  logic [3:0] iBin,
    output logic       oReady,
    output logic       oValid,
    output logic [7:0] oBin,
    output logic [3:0] oIdx,
    output logic       oLast,
    input  logic       iReady
);

    localparam int unsigned CntW = (PIX_PER_CELL > 1) ? $clog2(PIX_PER_CELL) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(PIX_PER_CELL - 1);
    localparam logic [3:0]      LastIdx = 4'(NBINS - 1);

    typedef enum logic [0:0] {
        StAccum,
        StDrain
    } state_e;

    state_e           state_q;
    logic [13:0]      acc_q [NBINS];
    logic [CntW-1:0]  cnt_q;
    logic [3:0]       idx_q;
    logic [13:0]      sel_acc;

    // Cell FSM: accumulate pixels, then hand out bins; reset wins over everything.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= StAccum;
            cnt_q   <= '0;
            idx_q   <= '0;
            for (int b = 0; b < NBINS; b++) begin
                acc_q[b] <= '0;
            end
        end else begin
            case (state_q)
                StAccum: begin
                    if (iValid) begin
                        // Out-of-range bins fall through every compare and only count.
                        for (int b = 0; b < NBINS; b++) begin
                            if (iBin == 4'(b)) begin
                                acc_q[b] <= acc_q[b] + {6'd0, iMag};
                            end
                        end
                        if (cnt_q == LastCnt) begin
                            cnt_q   <= '0;
                            idx_q   <= '0;
                            state_q <= StDrain;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (iReady) begin
                        if (idx_q == LastIdx) begin
                            idx_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= StAccum;
                            for (int b = 0; b < NBINS; b++) begin
                                acc_q[b] <= '0;
                            end
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end
                end
                default: state_q <= StAccum;
            endcase
        end
    end

    // Select the accumulator addressed by the drain index without a raw array index.
    always_comb begin
        sel_acc = '0;
        for (int b = 0; b < NBINS; b++) begin
            if (idx_q == 4'(b)) begin
                sel_acc = acc_q[b];
            end
        end
    end

    // Outputs derive only from registered state, so they hold while stalled.
    always_comb begin
        oReady = (state_q == StAccum);
        oValid = (state_q == StDrain);
        oIdx   = idx_q;
        oLast  = (state_q == StDrain) && (idx_q == LastIdx);
        oBin   = (sel_acc > 14'd255) ? 8'hFF : sel_acc[7:0];
    end

endmodule

// File: tb/tb_cell_hist_accum.sv
// Self-checking bench for cell_hist_accum: behavioural histogram model plus directed cells.
module tb_cell_hist_accum;

    localparam int PPC = 64;
    localparam int NB  = 9;

    logic       iClk = 1'b0;
    logic       iRst = 1'b0;
    logic       iValid = 1'b0;
    logic [7:0] iMag = '0;
    logic [3:0] iBin = '0;
    logic       iReady = 1'b1;
    logic       oReady, oValid, oLast;
    logic [7:0] oBin;
    logic [3:0] oIdx;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: pixel list reduced to per-bin sums, and drain position.
    int  m_sums [16];
    int  m_pix;
    bit  m_drain;
    int  m_idx;
    bit  m_started;
    bit  m_rst_chk;
    int  m_cells;
    int  mdl_cell [16];
    int  dut_cell [16];

    cell_hist_accum #(.PIX_PER_CELL(PPC), .NBINS(NB)) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iValid (iValid),
        .iMag   (iMag),
        .iBin   (iBin),
        .oReady (oReady),
        .oValid (oValid),
        .oBin   (oBin),
        .oIdx   (oIdx),
        .oLast  (oLast),
        .iReady (iReady)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Per-cycle compare, then advance the model by what happens at the next rising edge.
    always @(negedge iClk) begin
        if (m_started) begin
            chk("oReady", int'(oReady), int'(!m_drain));
            chk("oValid", int'(oValid), int'(m_drain));
            chk("oLast", int'(oLast), int'(m_drain && m_idx == NB - 1));
            if (m_drain) begin
                chk("oIdx", int'(oIdx), m_idx);
                chk("oBin", int'(oBin), sat(m_sums[m_idx]));
            end
            if (m_rst_chk && !iRst) begin
                chk("rst_oBin", int'(oBin), 0);
                chk("rst_oIdx", int'(oIdx), 0);
                m_rst_chk = 0;
            end
        end
        if (iRst) begin
            m_drain = 0; m_pix = 0; m_idx = 0;
            for (int b = 0; b < 16; b++) m_sums[b] = 0;
            m_started = 1; m_rst_chk = 1;
        end else if (m_started) begin
            if (!m_drain) begin
                if (iValid) begin
                    if (int'(iBin) < NB) m_sums[iBin] += int'(iMag);
                    m_pix++;
                    if (m_pix == PPC) begin
                        m_drain = 1; m_idx = 0; m_pix = 0;
                        for (int b = 0; b < 16; b++) mdl_cell[b] = sat(m_sums[b]);
                    end
                end
            end else if (iReady) begin
                dut_cell[oIdx] = int'(oBin);
                if (m_idx == NB - 1) begin
                    m_drain = 0; m_idx = 0; m_cells++;
                    for (int b = 0; b < 16; b++) m_sums[b] = 0;
                end else begin
                    m_idx++;
                end
            end
        end
    end

    task automatic do_reset(input int cycles);
        iRst = 1'b1;
        repeat (cycles) @(posedge iClk);
        #1 iRst = 1'b0;
    endtask

    // Present one pixel and hold it until the DUT takes it.
    task automatic send_pix(input int mag, input int bin);
        int n;
        bit r;
        iMag = 8'(mag); iBin = 4'(bin); iValid = 1'b1;
        n = 0;
        do begin
            r = oReady;
            @(posedge iClk); #1;
            n++;
        end while (!r && n < 1000);
        if (!r) chk("send_timeout", 0, 1);
        iValid = 1'b0;
    endtask

    task automatic send_cell(input int mag, input int bin);
        for (int i = 0; i < PPC; i++) send_pix(mag, bin);
    endtask

    // Drain with optional random stalls and optional junk pixels presented throughout.
    task automatic drain(input bit rnd_ready, input bit junk);
        int n;
        n = 0;
        while (!oReady && n < 500) begin
            iReady = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (junk) begin
                iValid = 1'b1; iMag = 8'hFF; iBin = 4'd0;
            end
            @(posedge iClk); #1;
            n++;
            if (oReady) iValid = 1'b0;
        end
        iValid = 1'b0;
        iReady = 1'b1;
        if (!oReady) chk("drain_timeout", 0, 1);
    endtask

    task automatic check_cell(input string nm, input int lit [16]);
        for (int b = 0; b < NB; b++) begin
            chk($sformatf("%s_dut_bin%0d", nm, b), dut_cell[b], lit[b]);
            chk($sformatf("%s_mdl_bin%0d", nm, b), mdl_cell[b], lit[b]);
        end
    endtask

    task automatic wait_idx(input int target);
        int n;
        n = 0;
        while (!(oValid && int'(oIdx) == target) && n < 200) begin
            @(posedge iClk); #1;
            n++;
        end
        if (n >= 200) chk("wait_idx_timeout", 0, 1);
    endtask

    initial begin
        int lit [16];
        int cells_before;
        for (int b = 0; b < 16; b++) begin
            m_sums[b] = 0; mdl_cell[b] = 0; dut_cell[b] = 0;
        end
        m_pix = 0; m_drain = 0; m_idx = 0; m_started = 0; m_rst_chk = 0; m_cells = 0;

        #1;
        do_reset(2);
        @(posedge iClk); #1;
        chk("after_rst_oReady", int'(oReady), 1);

        // Unit magnitudes all in bin 0.
        send_cell(1, 0);
        drain(1'b0, 1'b0);
        lit = '{default: 0}; lit[0] = 64;
        check_cell("c032", lit);
        chk("c032_ready_next", int'(oReady), 1);

        // Saturation.
        send_cell(200, 3);
        drain(1'b0, 1'b0);
        lit = '{default: 0}; lit[3] = 255;
        check_cell("c033", lit);

        // Out-of-range bins count but do not accumulate.
        for (int i = 0; i < PPC - 1; i++) send_pix(50, 12);
        chk("c034_not_drain_yet", int'(oValid), 0);
        send_pix(7, 1);
        chk("c034_drain_entered", int'(oValid), 1);
        drain(1'b0, 1'b0);
        lit = '{default: 0}; lit[1] = 7;
        check_cell("c034", lit);

        // Three-cycle stall at index 4.
        for (int i = 0; i < PPC; i++) send_pix($urandom_range(0, 255), i % NB);
        iReady = 1'b1;
        wait_idx(4);
        iReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("c035_stall_idx", int'(oIdx), 4);
            chk("c035_stall_bin", int'(oBin), mdl_cell[4]);
            if (k < 2) begin
                @(posedge iClk); #1;
            end
        end
        iReady = 1'b1;
        @(posedge iClk); #1;
        chk("c035_idx_after", int'(oIdx), 5);
        drain(1'b0, 1'b0);

        // Reset in the middle of a drain.
        for (int i = 0; i < PPC; i++) send_pix($urandom_range(0, 255), $urandom_range(0, 8));
        wait_idx(5);
        iRst = 1'b1;
        @(posedge iClk); #1;
        iRst = 1'b0;
        chk("c036_valid_after_rst", int'(oValid), 0);
        cells_before = m_cells;
        send_cell(2, 8);
        drain(1'b0, 1'b0);
        chk("c036_cell_count", m_cells - cells_before, 1);
        lit = '{default: 0}; lit[8] = 128;
        check_cell("c036", lit);

        // Pixels presented during drain must be ignored.
        for (int i = 0; i < PPC; i++) send_pix(10, 5);
        drain(1'b1, 1'b1);
        send_cell(3, 2);
        drain(1'b0, 1'b0);
        lit = '{default: 0}; lit[2] = 192;
        check_cell("c037", lit);

        // Reset in the middle of accumulation.
        for (int i = 0; i < 20; i++) send_pix(255, 6);
        do_reset(1);
        send_cell(1, 6);
        drain(1'b0, 1'b0);
        lit = '{default: 0}; lit[6] = 64;
        check_cell("mid_accum_rst", lit);

        // Random cells with gaps, illegal bins and downstream stalls.
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < PPC; i++) begin
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge iClk);
                #1;
                send_pix($urandom_range(0, 255),
                         ($urandom_range(0, 7) == 0) ? $urandom_range(9, 15)
                                                     : $urandom_range(0, 8));
            end
            drain(1'b1, c[0]);
        end

        repeat (3) @(posedge iClk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
